temp_to_celsius: RTL

Input-side counterpart of the temperature display path. The display path takes a stored Celsius value and converts it to Fahrenheit, Celsius or Kelvin for output. This block does the reverse: it accepts a temperature in a selected unit and converts it back to a signed Celsius value. The Fahrenheit case uses a multi-cycle shift-subtract divider. It sits between the switch/entry logic and the temperature register that feeds the display path.

---
 rtl/temp_pkg.sv | 23 ++
 rtl/udiv_const_seq.sv | 71 +++++++
 rtl/temp_to_celsius.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared unit codes, FSM states and conversion constants
package temp_pkg;

    typedef enum logic [1:0] {
        UNIT_C   = 2'b00,
        UNIT_F   = 2'b01,
        UNIT_K   = 2'b10,
        UNIT_RSV = 2'b11
    } unit_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Shared with the display-path conversion so both directions agree
    localparam int F_OFFSET = 32;
    localparam int K_OFFSET = 273;
    localparam int DIVISOR  = 9;

endpackage

// File: rtl/udiv_const_seq.sv
// rtl/udiv_const_seq.sv - sequential restoring divider by a fixed constant
module udiv_const_seq #(
    parameter int N       = 14,
    parameter int DIVISOR = 9
) (
    input  logic                                 clk,
    input  logic                                 clr,
    input  logic                                 load,
    input  logic [N-1:0]                         dividend,
    output logic [N-1:0]                         quotient,
    output logic [$clog2(DIVISOR+1):0]           remainder,
    output logic                                 fin
);

    // One spare remainder bit so the shifted trial value never overflows
    localparam int RW = $clog2(DIVISOR + 1);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  dvd_q;
    logic [N-1:0]  quo_q;
    logic [RW:0]   rem_q;
    logic [CW-1:0] cnt_q;
    logic          active_q;

    logic [RW:0]   trial;
    logic          take;
    logic [RW:0]   rem_nxt;
    logic [N-1:0]  quo_nxt;

    // One restoring step: bring down the next dividend bit and try the subtract
    always_comb begin
        trial   = (rem_q << 1) | (RW+1)'(dvd_q[N-1]);
        take    = (trial >= (RW+1)'(DIVISOR));
        rem_nxt = take ? (trial - (RW+1)'(DIVISOR)) : trial;
        quo_nxt = (quo_q << 1) | N'(take);
    end

    // Iteration registers; the counter walks 0..N-1 while active
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dvd_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            dvd_q    <= dividend;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            dvd_q <= dvd_q << 1;
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                active_q <= 1'b0;
            end
        end
    end

    // Results include the bit being produced this cycle, so they are final while fin is high
    always_comb begin
        fin       = active_q && (cnt_q == LAST);
        quotient  = active_q ? quo_nxt : quo_q;
        remainder = active_q ? rem_nxt : rem_q;
    end

endmodule

// File: rtl/temp_to_celsius.sv
// rtl/temp_to_celsius.sv - converts a Celsius/Fahrenheit/Kelvin entry to signed Celsius
module temp_to_celsius #(
    parameter int W        = 12,
    parameter int F_OFFSET = temp_pkg::F_OFFSET,
    parameter int K_OFFSET = temp_pkg::K_OFFSET
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] din,
    input  logic [1:0]   sel,
    input  logic         st,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] celsius,
    output logic         err
);

    import temp_pkg::*;

    localparam int REM_W = $clog2(DIVISOR + 1) + 1;

    state_t         state_q;
    state_t         state_nxt;

    logic [W-1:0]   din_q;
    unit_t          sel_q;
    logic           neg_q;
    logic [W-1:0]   celsius_q;
    logic           err_q;

    logic [W:0]     x_off;
    logic [W+2:0]   x_ext;
    logic [W+2:0]   t_scaled;
    logic           t_neg;
    logic [W+1:0]   t_mag;
    logic [W-1:0]   k_val;

    logic           div_load;
    logic [W+1:0]   div_q;
    logic [REM_W-1:0] div_rem_unused;
    logic           div_fin;

    // Fahrenheit pre-scale (F - offset) * 5 via shift-add, plus the Kelvin offset
    always_comb begin
        x_off    = {din_q[W-1], din_q} - (W+1)'(F_OFFSET);
        x_ext    = {{2{x_off[W]}}, x_off};
        t_scaled = (x_ext << 2) + x_ext;
        t_neg    = t_scaled[W+2];
        t_mag    = (W+2)'(t_neg ? -t_scaled : t_scaled);
        k_val    = din_q - W'(K_OFFSET);
        div_load = (state_q == PREP) && (sel_q == UNIT_F);
    end

    udiv_const_seq #(
        .N       (W + 2),
        .DIVISOR (DIVISOR)
    ) u_div (
        .clk       (clk),
        .clr       (clr),
        .load      (div_load),
        .dividend  (t_mag),
        .quotient  (div_q),
        .remainder (div_rem_unused),
        .fin       (div_fin)
    );

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; st only matters in IDLE so requests while busy are dropped
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (st) state_nxt = PREP;
            PREP: state_nxt = (sel_q == UNIT_F) ? DIV : DONE;
            DIV:  if (div_fin) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and result registers; result lands on the edge entering DONE
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            din_q     <= '0;
            sel_q     <= UNIT_C;
            neg_q     <= 1'b0;
            celsius_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (st) begin
                        din_q <= din;
                        sel_q <= unit_t'(sel);
                    end
                end
                PREP: begin
                    case (sel_q)
                        UNIT_C: begin
                            celsius_q <= din_q;
                            err_q     <= 1'b0;
                        end
                        UNIT_K: begin
                            celsius_q <= din_q[W-1] ? '0 : k_val;
                            err_q     <= din_q[W-1];
                        end
                        UNIT_F: begin
                            neg_q <= t_neg;
                            err_q <= 1'b0;
                        end
                        default: begin
                            celsius_q <= '0;
                            err_q     <= 1'b1;
                        end
                    endcase
                end
                DIV: begin
                    if (div_fin) begin
                        celsius_q <= neg_q ? W'(-div_q) : W'(div_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        celsius = celsius_q;
        err     = err_q;
    end

endmodule
